// File: rtl/bcd_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_tick_counter
// Description : Multi-digit up/down BCD counter advanced by qualified ticks,
//               with clear, sanitised parallel load and wrap carry pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_tick_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  tick,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry
);

  localparam logic [3:0] c_nine = 4'd9;
  localparam logic [3:0] c_zero = 4'd0;

  logic [4*DIGITS-1:0] r_bcd;
  logic                r_carry;
  logic [4*DIGITS-1:0] w_next;
  logic [4*DIGITS-1:0] w_load;
  // w_prop[i] = digit i receives a +1/-1 step; w_prop[DIGITS] = whole-counter wrap
  logic [DIGITS:0]     w_prop;

  assign w_prop[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] w_cur;
    logic [3:0] w_step;
    logic       w_at_limit;

    assign w_cur       = r_bcd[4*i +: 4];
    assign w_at_limit  = up ? (w_cur == c_nine) : (w_cur == c_zero);
    assign w_step      = up ? (w_cur + 4'd1) : (w_cur - 4'd1);
    assign w_next[4*i +: 4] = !w_prop[i] ? w_cur :
                              (w_at_limit ? (up ? c_zero : c_nine) : w_step);
    assign w_prop[i+1] = w_prop[i] & w_at_limit;

    assign w_load[4*i +: 4] = (load_value[4*i +: 4] > c_nine) ? c_nine
                                                               : load_value[4*i +: 4];
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_bcd   <= '0;
      r_carry <= 1'b0;
    end else if (clear) begin
      r_bcd   <= '0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_bcd   <= w_load;
      r_carry <= 1'b0;
    end else if (tick && enable) begin
      r_bcd   <= w_next;
      r_carry <= w_prop[DIGITS];
    end else begin
      r_carry <= 1'b0;
    end
  end

  assign bcd   = r_bcd;
  assign carry = r_carry;

endmodule
`default_nettype wire
